// File: rtl/johnson_pkg.sv
// Shared types and pure helpers for Johnson (twisted-ring) code consumers.
//   lock_state_e : lock FSM states (UNLOCKED, LOCKING, LOCKED)
//   iw(n)        : index width for an n-stage Johnson code, $clog2(2n)
//   is_legal()   : legality check of an n-bit Johnson word (zero-extended to MAX_N)
//   decode()     : step index of a legal n-bit Johnson word
package johnson_pkg;

  localparam int MAX_N = 32;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  function automatic int iw(input int n);
    return $clog2(2 * n);
  endfunction

  // MSB set: ones must run contiguously down from the MSB.
  // MSB clear: ones must run contiguously up from the LSB (all-zero passes).
  function automatic logic is_legal(input logic [MAX_N-1:0] code, input int n);
    logic ok;
    logic seen_zero;
    ok        = 1'b1;
    seen_zero = 1'b0;
    if (code[n-1]) begin
      for (int i = MAX_N - 1; i >= 0; i--) begin
        if (i < n) begin
          if (!code[i]) seen_zero = 1'b1;
          else if (seen_zero) ok = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < MAX_N; i++) begin
        if (i < n) begin
          if (!code[i]) seen_zero = 1'b1;
          else if (seen_zero) ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

  // Filling phase (MSB set) counts up with the number of ones; draining
  // phase (MSB clear) counts the remaining ones back from 2n.
  function automatic int decode(input logic [MAX_N-1:0] code, input int n);
    int p;
    p = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if ((i < n) && code[i]) p++;
    end
    if (code[n-1]) return p;
    else if (p != 0) return 2 * n - p;
    else return 0;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson word decoder.
//   code_in : N-bit Johnson state word (bit N-1 is the stage fed by the inverted LSB)
//   legal   : 1 when code_in is one of the 2N legal words
//   index   : decoded step index (meaningful only when legal = 1)
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = iw(N)
) (
  input  logic [N-1:0]  code_in,
  output logic          legal,
  output logic [IW-1:0] index
);

  logic [MAX_N-1:0] code_ext;
  int               dec;

  always_comb begin
    code_ext        = '0;
    code_ext[N-1:0] = code_in;
    legal           = is_legal(code_ext, N);
    dec             = decode(code_ext, N);
    index           = dec[IW-1:0];
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code integrity checker and decoder.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   code_in      : N-bit Johnson state word, qualified by code_valid
//   index        : step index of the last legal sample (held otherwise)
//   index_valid  : pulse, index updated from a legal sample
//   illegal_code : pulse, sample was not a legal Johnson word
//   seq_error    : pulse, legal word out of sequence while locked
//   wrap         : pulse, locked advance from 2N-1 to 0
//   locked       : level, FSM is in LOCKED
//   err_count    : saturating count of illegal_code + seq_error events
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8,
  parameter int IW       = iw(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     code_in,
  input  logic             code_valid,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             illegal_code,
  output logic             seq_error,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int RW = $clog2(LOCK_LEN + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_LEN);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  lock_state_e   state_p1, state_nxt;
  logic [RW-1:0] run_p1, run_nxt;

  logic          legal_p0;
  logic [IW-1:0] dec_idx_p0;
  logic          vld_p0;
  logic          step_ok_p0;
  logic [IW-1:0] exp_idx_p0;

  logic [IW-1:0] index_nxt;
  logic          iv_nxt, ill_nxt, seq_nxt, wrap_nxt, err_inc;

  // ---- stage p0: decode the incoming sample ----
  johnson_code_decode #(.N(N), .IW(IW)) u_dec (
    .code_in (code_in),
    .legal   (legal_p0),
    .index   (dec_idx_p0)
  );

  assign vld_p0     = code_valid;
  // index register doubles as the previous-index reference
  assign exp_idx_p0 = (index == LAST_IDX) ? '0 : index + IW'(1);
  assign step_ok_p0 = (dec_idx_p0 == exp_idx_p0);

  always_comb begin
    state_nxt = state_p1;
    run_nxt   = run_p1;
    index_nxt = index;
    iv_nxt    = 1'b0;
    ill_nxt   = 1'b0;
    seq_nxt   = 1'b0;
    wrap_nxt  = 1'b0;
    err_inc   = 1'b0;
    if (vld_p0) begin
      if (!legal_p0) begin
        ill_nxt   = 1'b1;
        err_inc   = 1'b1;
        state_nxt = UNLOCKED;
        run_nxt   = '0;
      end else begin
        index_nxt = dec_idx_p0;
        iv_nxt    = 1'b1;
        unique case (state_p1)
          UNLOCKED: begin
            state_nxt = LOCKING;
            run_nxt   = '0;
          end
          LOCKING: begin
            if (step_ok_p0) begin
              run_nxt = run_p1 + RW'(1);
              if (run_p1 + RW'(1) == RUN_MAX) state_nxt = LOCKED;
            end else begin
              run_nxt = '0;
            end
          end
          LOCKED: begin
            if (step_ok_p0) begin
              wrap_nxt = (index == LAST_IDX);
            end else begin
              seq_nxt   = 1'b1;
              err_inc   = 1'b1;
              state_nxt = LOCKING;
              run_nxt   = '0;
            end
          end
          default: begin
            state_nxt = UNLOCKED;
            run_nxt   = '0;
          end
        endcase
      end
    end
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1     <= UNLOCKED;
      run_p1       <= '0;
      index        <= '0;
      index_valid  <= 1'b0;
      illegal_code <= 1'b0;
      seq_error    <= 1'b0;
      wrap         <= 1'b0;
      err_count    <= '0;
    end else begin
      state_p1     <= state_nxt;
      run_p1       <= run_nxt;
      index        <= index_nxt;
      index_valid  <= iv_nxt;
      illegal_code <= ill_nxt;
      seq_error    <= seq_nxt;
      wrap         <= wrap_nxt;
      if (err_inc) err_count <= sat_inc(err_count);
    end
  end

  assign locked = (state_p1 == LOCKED);

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the team's 4-stage Johnson (twisted-ring) counter. It samples a Johnson-coded state word, decodes it to a binary step index, and checks every sample for code legality and correct step-by-step advance. It locks after a run of correct advances and reports illegal codes and sequence slips. It sits downstream of any Johnson-counter source, such as a remote counter or a clock-domain-crossed phase word, as its integrity checker and decoder.

## Interface
- N, default 4: number of Johnson stages (≥2); sequence length is 2N.
- LOCK_LEN, default 3: consecutive correct advances required to declare lock (≥1).
- ERR_W, default 8: width of the saturating error counter.
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- code_in  input  N  Johnson state word; bit N-1 is the stage loaded with the inverted LSB.
- code_valid  input  1  qualifies code_in for this cycle.
- index  output  IW=$clog2(2N)  decoded step index of the last legal sample.
- index_valid  output  1  one-cycle pulse: index updated from a legal sample.
- illegal_code  output  1  one-cycle pulse: the sample was not a legal Johnson word.
- seq_error  output  1  one-cycle pulse: a legal word arrived out of sequence while locked.
- wrap  output  1  one-cycle pulse: locked advance from 2N-1 to 0.
- locked  output  1  level: decoder is in LOCKED.
- err_count  output  ERR_W  saturating count of illegal_code plus seq_error events.

## Operation
- Source sequence (N=4): 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, repeating. These map to indices 0 through 7.
- Legal words:
  - all-zero;
  - MSB=1 with ones contiguous from the MSB (1..10..0);
  - MSB=0 with ones contiguous from the LSB (0..01..1).
  - All other 2^N − 2N words are illegal.
- Decode (p = popcount):
  - MSB=1: index = p.
  - MSB=0 and p>0: index = 2N − p.
  - All-zero: index = 0.
- Correct step: new index = (previous index + 1) mod 2N. A repeated index counts as a wrong step.
- States: UNLOCKED, LOCKING, LOCKED. A run counter counts 0..LOCK_LEN.
- Transitions on a legal sample:
  - UNLOCKED → LOCKING; run = 0.
  - LOCKING, correct step → run + 1. When run reaches LOCK_LEN → LOCKED.
  - LOCKING, wrong step → stay in LOCKING; run = 0. No error is reported.
  - LOCKED, correct step → stay in LOCKED. Pulse wrap if previous index = 2N−1.
  - LOCKED, wrong step → seq_error; err_count++; go to LOCKING with run = 0.
- On every legal sample: index ← decoded value; index_valid = 1.
- On an illegal sample, in any state:
  - illegal_code = 1 and err_count++;
  - index holds and index_valid = 0;
  - state → UNLOCKED and run = 0.
- When code_valid = 0: no state change, all pulses 0, index and err_count hold.
- err_count saturates at 2^ERR_W − 1 and never wraps.

## Timing
- All outputs are registered. A sample presented at edge k is reflected in the outputs after edge k.
- Latency is 1 cycle. Pulses last exactly one cycle.
- locked rises in the same cycle as the index_valid pulse of the LOCK_LEN-th correct advance.
- locked falls in the same cycle as the seq_error or illegal_code pulse that caused the exit.
- Reset values: index = 0, index_valid = 0, illegal_code = 0, seq_error = 0, wrap = 0, locked = 0, err_count = 0. State = UNLOCKED, run = 0.
- reset has priority over code_valid in the same cycle; that sample is discarded.
- Back-to-back valid samples are accepted every cycle. Gaps of any length between samples are allowed.

## Structure
- Package johnson_pkg holds:
  - the state enum (UNLOCKED, LOCKING, LOCKED);
  - the IW width function;
  - pure functions for legality check and decode, parameterised on N.
- Sub-module johnson_code_decode: combinational; inputs code_in; outputs legal and index. It is reused by any future Johnson consumer.
- Top level contains the FSM, run counter, previous-index register, output registers and the saturating error counter.

## Test plan
- Lock-in: reset, then stream 0000, 1000, 1100, 1110 on consecutive cycles. Required: index 0, 1, 2, 3 with index_valid each cycle; locked = 1 only after the 4th sample (N=4, LOCK_LEN=3).
- Wrap: continue the locked stream through 0001 → 0000. Required: wrap = 1 in the cycle index becomes 0; locked stays 1.
- Illegal word: while locked at index 5, drive 1010. Required: illegal_code = 1, index stays 5, index_valid = 0, locked = 0, err_count = 1.
- Slip: while locked at index 2 (1100), drive 1111. Required: seq_error = 1, index = 4, locked = 0, err_count + 1. Three further correct steps relock.
- Gaps and hold: drop code_valid for 5 cycles mid-lock, then resume with the correct next code. Required: no pulses during the gap; locked stays 1.
- Saturation and reset: with ERR_W = 2, drive 5 illegal words, then reset with code_valid = 1. Required: err_count stops at 3; all outputs are 0 the cycle after reset.
